pd_rt_dispatch_ctrl: RTL and testbench
======================================

# pd_rt_dispatch_ctrl

Sequential per-core task-dispatch controller between the Patch Dispatcher and one RT core. It accepts a task descriptor over a valid/ready handshake and preloads the core register file: pixel id and thread id go to scalar registers, ray origin and direction to vector registers. It then releases the core from kernel mode and watches for task finish or context switch, preempting the core if a watchdog expires. It returns a completion or suspension record, including the saved PC and SP, to the dispatcher.

## Interface
- THREAD_W, 6, thread id width
- DATA_W, 32, scalar/PC/SP/pixel width
- VEC_W, 128, vector register width
- SREG_AW, 5, scalar register address width
- VREG_AW, 4, vector register address width
- PIXEL_REG, 1, scalar register receiving pixel id
- TID_REG, 2, scalar register receiving zero-extended thread id
- ORIGIN_VREG, 1, vector register receiving ray origin
- DIR_VREG, 2, vector register receiving ray direction
- TIMEOUT, 0, RUN cycles before preempt; 0 disables watchdog
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- task_valid / task_ready  in / out  1  descriptor handshake
- task_tid  in  THREAD_W  thread id
- task_pixel, task_pc, task_sp  in  DATA_W  pixel id, start PC, start SP
- task_origin, task_dir  in  VEC_W  ray origin, direction
- s_wen / s_waddr / s_wdata  out  1 / SREG_AW / DATA_W  scalar RF write port
- v_wen / v_waddr / v_wdata  out  1 / VREG_AW / VEC_W  vector RF write port
- core_pc, core_sp  out  DATA_W  start PC/SP presented to core
- core_start  out  1  one-cycle start pulse
- kernel_mode  out  1  high = core held in kernel mode
- preempt  out  1  watchdog request to core to context switch
- task_finish_in, context_switch_in  in  1  core status pulses
- core_pc_in, core_sp_in  in  DATA_W  live PC/SP of core, valid with context_switch_in
- rpt_valid / rpt_ready  out / in  1  report handshake
- rpt_tid  out  THREAD_W  thread id of report
- rpt_switched  out  1  0 = finished, 1 = suspended
- rpt_pc, rpt_sp  out  DATA_W  saved PC/SP (0 when finished)

## Operation
- States: IDLE, LOAD0, LOAD1, START, RUN, REPORT.
- IDLE: task_ready=1. Valid&ready latches all task_* fields → LOAD0.
- LOAD0: s_wen=1, s_waddr=PIXEL_REG, s_wdata=pixel; v_wen=1, v_waddr=ORIGIN_VREG, v_wdata=origin → LOAD1.
- LOAD1: s_waddr=TID_REG, s_wdata={0,tid}; v_waddr=DIR_VREG, v_wdata=dir → START.
- START: core_start=1 for this cycle; core_pc/core_sp driven from latched PC/SP in LOAD0..START → RUN.
- kernel_mode=0 only in START and RUN; 1 otherwise.
- RUN: cycle counter increments from 0. If TIMEOUT≠0 and count reaches TIMEOUT, preempt rises and stays high until leaving RUN.
- In RUN, task_finish_in → REPORT with switched=0 and pc/sp=0. context_switch_in → REPORT with switched=1 and pc/sp captured from core_pc_in/core_sp_in. If both arrive in the same cycle, finish wins.
- Status pulses outside RUN are ignored.
- REPORT: rpt_valid=1 with fields stable until rpt_ready. Handshake → IDLE, one cycle later task_ready=1. No bypass to the next task in the same cycle.
- Counter width = max(1, $clog2(TIMEOUT+1)); saturates at TIMEOUT.

## Timing
- Reset (async, rst_n=0): state=IDLE; task_ready=1; kernel_mode=1; all other outputs and latched fields 0; counter 0.
- Reset mid-task discards the task; no report is produced.
- Accept at edge N: RF writes at N+1 and N+2, core_start at N+3, RUN from N+4.
- Status pulse sampled at edge M in RUN: rpt_valid=1 from M+1.
- Minimum task turnaround with rpt_ready tied 1 is 6 cycles from accept to next task_ready.
- Report outputs are registered. RF write outputs are decoded combinationally from state plus latched registers only, with no task_* input paths.

## Test plan
- Reset: assert rst_n=0 mid-RUN → next cycle kernel_mode=1, task_ready=1, rpt_valid=0, preempt=0, and no report follows.
- Normal finish: tid=5, pixel=0x1234, pc=0x400, sp=0x8000 → s-writes r1=0x1234 then r2=5, v-writes v1/v2 = origin/dir, start pulse with core_pc=0x400. Finish pulse → rpt tid=5, switched=0, pc=sp=0.
- Context switch: context_switch_in with core_pc_in=0x47C, core_sp_in=0x7FF0 → rpt switched=1, pc=0x47C, sp=0x7FF0.
- Watchdog: TIMEOUT=10, no status → preempt high exactly 10 cycles into RUN. Context switch 3 cycles later → preempt drops and report switched=1.
- Collision/backpressure: finish and switch in the same cycle → switched=0. Hold rpt_ready=0 for 5 cycles → fields stable, task_ready=0 and a new task_valid is not accepted.
- Stray pulses: task_finish_in during LOAD0 → ignored, sequence completes normally.

Source files
------------

// File: rtl/pd_rt_dispatch_ctrl_if.sv
// Bundle of dispatcher, register-file, core-control and report signals for one RT core dispatch slot.
// The controller uses the slave modport; the dispatcher/core side uses master.
interface pd_rt_dispatch_ctrl_if #(
    parameter int THREAD_W = 6,
    parameter int DATA_W   = 32,
    parameter int VEC_W    = 128,
    parameter int SREG_AW  = 5,
    parameter int VREG_AW  = 4
);
    logic                task_valid;
    logic                task_ready;
    logic [THREAD_W-1:0] task_tid;
    logic [DATA_W-1:0]   task_pixel;
    logic [DATA_W-1:0]   task_pc;
    logic [DATA_W-1:0]   task_sp;
    logic [VEC_W-1:0]    task_origin;
    logic [VEC_W-1:0]    task_dir;
    logic                s_wen;
    logic [SREG_AW-1:0]  s_waddr;
    logic [DATA_W-1:0]   s_wdata;
    logic                v_wen;
    logic [VREG_AW-1:0]  v_waddr;
    logic [VEC_W-1:0]    v_wdata;
    logic [DATA_W-1:0]   core_pc;
    logic [DATA_W-1:0]   core_sp;
    logic                core_start;
    logic                kernel_mode;
    logic                preempt;
    logic                task_finish_in;
    logic                context_switch_in;
    logic [DATA_W-1:0]   core_pc_in;
    logic [DATA_W-1:0]   core_sp_in;
    logic                rpt_valid;
    logic                rpt_ready;
    logic [THREAD_W-1:0] rpt_tid;
    logic                rpt_switched;
    logic [DATA_W-1:0]   rpt_pc;
    logic [DATA_W-1:0]   rpt_sp;

    modport slave (
        input  task_valid, task_tid, task_pixel, task_pc, task_sp, task_origin, task_dir,
        input  task_finish_in, context_switch_in, core_pc_in, core_sp_in, rpt_ready,
        output task_ready, s_wen, s_waddr, s_wdata, v_wen, v_waddr, v_wdata,
        output core_pc, core_sp, core_start, kernel_mode, preempt,
        output rpt_valid, rpt_tid, rpt_switched, rpt_pc, rpt_sp
    );

    modport master (
        output task_valid, task_tid, task_pixel, task_pc, task_sp, task_origin, task_dir,
        output task_finish_in, context_switch_in, core_pc_in, core_sp_in, rpt_ready,
        input  task_ready, s_wen, s_waddr, s_wdata, v_wen, v_waddr, v_wdata,
        input  core_pc, core_sp, core_start, kernel_mode, preempt,
        input  rpt_valid, rpt_tid, rpt_switched, rpt_pc, rpt_sp
    );
endinterface

// File: rtl/pd_rt_dispatch_ctrl.sv
// Per-core dispatch controller: preloads the RF from a task descriptor, runs the core under an
// optional watchdog and returns a finish/suspend record with the saved PC/SP.
module pd_rt_dispatch_ctrl #(
    parameter int THREAD_W    = 6,
    parameter int DATA_W      = 32,
    parameter int VEC_W       = 128,
    parameter int SREG_AW     = 5,
    parameter int VREG_AW     = 4,
    parameter int PIXEL_REG   = 1,
    parameter int TID_REG     = 2,
    parameter int ORIGIN_VREG = 1,
    parameter int DIR_VREG    = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic clk,
    input  logic rst_n,
    pd_rt_dispatch_ctrl_if.slave bus
);
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam bit WD_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD0  = 3'd1,
        S_LOAD1  = 3'd2,
        S_START  = 3'd3,
        S_RUN    = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [THREAD_W-1:0] tid_r;
    logic [DATA_W-1:0]   pixel_r, pc_r, sp_r;
    logic [VEC_W-1:0]    origin_r, dir_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                rpt_valid_r, rpt_switched_r;
    logic [THREAD_W-1:0] rpt_tid_r;
    logic [DATA_W-1:0]   rpt_pc_r, rpt_sp_r;
    logic                accept_s, fin_s, sw_s, done_s;

    assign accept_s = bus.task_valid && (state_r == S_IDLE);
    assign fin_s    = bus.task_finish_in && (state_r == S_RUN);
    assign sw_s     = bus.context_switch_in && (state_r == S_RUN);
    assign done_s   = rpt_valid_r && bus.rpt_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_s;
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:   if (accept_s) state_s = S_LOAD0; else state_s = S_IDLE;
            S_LOAD0:  state_s = S_LOAD1;
            S_LOAD1:  state_s = S_START;
            S_START:  state_s = S_RUN;
            S_RUN:    if (fin_s || sw_s) state_s = S_REPORT; else state_s = S_RUN;
            S_REPORT: if (bus.rpt_ready) state_s = S_IDLE; else state_s = S_REPORT;
            default:  state_s = S_IDLE;
        endcase
    end

    // Descriptor latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tid_r    <= '0;
            pixel_r  <= '0;
            pc_r     <= '0;
            sp_r     <= '0;
            origin_r <= '0;
            dir_r    <= '0;
        end else if (accept_s) begin
            tid_r    <= bus.task_tid;
            pixel_r  <= bus.task_pixel;
            pc_r     <= bus.task_pc;
            sp_r     <= bus.task_sp;
            origin_r <= bus.task_origin;
            dir_r    <= bus.task_dir;
        end else begin
            tid_r    <= tid_r;
            pixel_r  <= pixel_r;
            pc_r     <= pc_r;
            sp_r     <= sp_r;
            origin_r <= origin_r;
            dir_r    <= dir_r;
        end
    end

    // RUN-cycle counter, saturating so the watchdog level holds until RUN is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt_r <= '0;
        else if (state_r != S_RUN)   cnt_r <= '0;
        else if (cnt_r != CNT_MAX)   cnt_r <= cnt_r + CNT_W'(1);
        else                         cnt_r <= cnt_r;
    end

    // Report record; finish has priority over a simultaneous context switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_valid_r    <= 1'b0;
            rpt_switched_r <= 1'b0;
            rpt_tid_r      <= '0;
            rpt_pc_r       <= '0;
            rpt_sp_r       <= '0;
        end else if (fin_s || sw_s) begin
            rpt_valid_r    <= 1'b1;
            rpt_switched_r <= !fin_s;
            rpt_tid_r      <= tid_r;
            rpt_pc_r       <= fin_s ? '0 : bus.core_pc_in;
            rpt_sp_r       <= fin_s ? '0 : bus.core_sp_in;
        end else if (done_s) begin
            rpt_valid_r    <= 1'b0;
            rpt_switched_r <= 1'b0;
            rpt_tid_r      <= '0;
            rpt_pc_r       <= '0;
            rpt_sp_r       <= '0;
        end else begin
            rpt_valid_r    <= rpt_valid_r;
            rpt_switched_r <= rpt_switched_r;
            rpt_tid_r      <= rpt_tid_r;
            rpt_pc_r       <= rpt_pc_r;
            rpt_sp_r       <= rpt_sp_r;
        end
    end

    // Register-file preload and core control decoded from state and latched fields only
    always_comb begin
        bus.s_wen   = 1'b0;
        bus.s_waddr = '0;
        bus.s_wdata = '0;
        bus.v_wen   = 1'b0;
        bus.v_waddr = '0;
        bus.v_wdata = '0;
        case (state_r)
            S_LOAD0: begin
                bus.s_wen   = 1'b1;
                bus.s_waddr = SREG_AW'(PIXEL_REG);
                bus.s_wdata = pixel_r;
                bus.v_wen   = 1'b1;
                bus.v_waddr = VREG_AW'(ORIGIN_VREG);
                bus.v_wdata = origin_r;
            end
            S_LOAD1: begin
                bus.s_wen   = 1'b1;
                bus.s_waddr = SREG_AW'(TID_REG);
                bus.s_wdata = DATA_W'(tid_r);
                bus.v_wen   = 1'b1;
                bus.v_waddr = VREG_AW'(DIR_VREG);
                bus.v_wdata = dir_r;
            end
            default: begin
                bus.s_wen = 1'b0;
                bus.v_wen = 1'b0;
            end
        endcase
    end

    // Core-facing control levels
    always_comb begin
        bus.task_ready  = (state_r == S_IDLE);
        bus.core_start  = (state_r == S_START);
        bus.kernel_mode = !((state_r == S_START) || (state_r == S_RUN));
        bus.preempt     = WD_EN && (state_r == S_RUN) && (cnt_r == CNT_MAX);
        if ((state_r == S_LOAD0) || (state_r == S_LOAD1) || (state_r == S_START)) begin
            bus.core_pc = pc_r;
            bus.core_sp = sp_r;
        end else begin
            bus.core_pc = '0;
            bus.core_sp = '0;
        end
    end

    assign bus.rpt_valid    = rpt_valid_r;
    assign bus.rpt_switched = rpt_switched_r;
    assign bus.rpt_tid      = rpt_tid_r;
    assign bus.rpt_pc       = rpt_pc_r;
    assign bus.rpt_sp       = rpt_sp_r;
endmodule

// File: tb/tb_pd_rt_dispatch_ctrl.sv
// Directed bench for pd_rt_dispatch_ctrl: table of tasks plus watchdog, backpressure and reset sequences.
module tb_pd_rt_dispatch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pd_rt_dispatch_ctrl_if #(.THREAD_W(6), .DATA_W(32), .VEC_W(128), .SREG_AW(5), .VREG_AW(4)) bus ();

    pd_rt_dispatch_ctrl #(
        .THREAD_W(6), .DATA_W(32), .VEC_W(128), .SREG_AW(5), .VREG_AW(4),
        .PIXEL_REG(1), .TID_REG(2), .ORIGIN_VREG(1), .DIR_VREG(2), .TIMEOUT(10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]   tid;
        logic [31:0]  pixel, pc, sp;
        logic [127:0] origin, dir;
        int           run;
        bit           fin, sw, stray;
        logic [31:0]  cpc, csp;
        bit           exp_sw;
        logic [31:0]  exp_pc, exp_sp;
    } vec_t;

    vec_t tbl[4];
    vec_t wd_v, bp_v, rs_v;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drives one descriptor and checks LOAD0, LOAD1, START; returns at the first RUN cycle.
    task automatic launch(input vec_t v);
        int guard = 0;
        while (bus.task_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", bus.task_ready, 1'b1);
        bus.task_valid = 1'b1; bus.task_tid = v.tid; bus.task_pixel = v.pixel;
        bus.task_pc = v.pc; bus.task_sp = v.sp; bus.task_origin = v.origin; bus.task_dir = v.dir;
        @(negedge clk);
        bus.task_valid = 1'b0; bus.task_tid = ~v.tid; bus.task_pixel = ~v.pixel;
        bus.task_pc = ~v.pc; bus.task_sp = ~v.sp; bus.task_origin = ~v.origin; bus.task_dir = ~v.dir;
        if (v.stray) begin
            bus.task_finish_in = 1'b1;
            bus.context_switch_in = 1'b1;
        end
        check("load0_s_wen", bus.s_wen, 1'b1);
        check("load0_s_waddr", bus.s_waddr, 5'd1);
        check("load0_s_wdata", bus.s_wdata, v.pixel);
        check("load0_v_wen", bus.v_wen, 1'b1);
        check("load0_v_waddr", bus.v_waddr, 4'd1);
        check("load0_v_wdata", bus.v_wdata, v.origin);
        check("load0_task_ready", bus.task_ready, 1'b0);
        check("load0_kernel_mode", bus.kernel_mode, 1'b1);
        check("load0_core_pc", bus.core_pc, v.pc);
        @(negedge clk);
        bus.task_finish_in = 1'b0;
        bus.context_switch_in = 1'b0;
        check("load1_s_wen", bus.s_wen, 1'b1);
        check("load1_s_waddr", bus.s_waddr, 5'd2);
        check("load1_s_wdata", bus.s_wdata, {26'd0, v.tid});
        check("load1_v_waddr", bus.v_waddr, 4'd2);
        check("load1_v_wdata", bus.v_wdata, v.dir);
        check("load1_core_start", bus.core_start, 1'b0);
        @(negedge clk);
        check("start_core_start", bus.core_start, 1'b1);
        check("start_kernel_mode", bus.kernel_mode, 1'b0);
        check("start_core_pc", bus.core_pc, v.pc);
        check("start_core_sp", bus.core_sp, v.sp);
        check("start_s_wen", bus.s_wen, 1'b0);
        @(negedge clk);
        check("run_core_start", bus.core_start, 1'b0);
        check("run_kernel_mode", bus.kernel_mode, 1'b0);
        check("run_rpt_valid", bus.rpt_valid, 1'b0);
        check("run_core_pc", bus.core_pc, 32'd0);
    endtask

    // Applies the status pulses now, checks the report next cycle and completes the handshake.
    task automatic report(input vec_t v);
        bus.task_finish_in = v.fin; bus.context_switch_in = v.sw;
        bus.core_pc_in = v.cpc; bus.core_sp_in = v.csp;
        @(negedge clk);
        bus.task_finish_in = 1'b0; bus.context_switch_in = 1'b0;
        bus.core_pc_in = 32'h0BAD_F00D; bus.core_sp_in = 32'h0BAD_F00D;
        check("rpt_valid", bus.rpt_valid, 1'b1);
        check("rpt_tid", bus.rpt_tid, v.tid);
        check("rpt_switched", bus.rpt_switched, v.exp_sw);
        check("rpt_pc", bus.rpt_pc, v.exp_pc);
        check("rpt_sp", bus.rpt_sp, v.exp_sp);
        check("rpt_kernel_mode", bus.kernel_mode, 1'b1);
        check("rpt_preempt", bus.preempt, 1'b0);
        check("rpt_task_ready", bus.task_ready, 1'b0);
        bus.rpt_ready = 1'b1;
        @(negedge clk);
        bus.rpt_ready = 1'b0;
        check("post_rpt_valid", bus.rpt_valid, 1'b0);
        check("post_task_ready", bus.task_ready, 1'b1);
    endtask

    initial begin
        bus.task_valid = 1'b0; bus.task_tid = '0; bus.task_pixel = '0; bus.task_pc = '0;
        bus.task_sp = '0; bus.task_origin = '0; bus.task_dir = '0; bus.task_finish_in = 1'b0;
        bus.context_switch_in = 1'b0; bus.core_pc_in = '0; bus.core_sp_in = '0; bus.rpt_ready = 1'b0;

        tbl[0] = '{tid: 6'd5, pixel: 32'h0000_1234, pc: 32'h0000_0400, sp: 32'h0000_8000,
                   origin: 128'h1111_2222_3333_4444_5555_6666_7777_8888, dir: 128'hA5A5_0000_FFFF_0001_8000_0000_0000_0042,
                   run: 2, fin: 1'b1, sw: 1'b0, stray: 1'b0, cpc: 32'hDEAD_BEEF, csp: 32'hDEAD_BEEF,
                   exp_sw: 1'b0, exp_pc: 32'd0, exp_sp: 32'd0};
        tbl[1] = '{tid: 6'h2A, pixel: 32'hCAFE_0001, pc: 32'h0000_1000, sp: 32'h0000_7000,
                   origin: 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, dir: 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0001,
                   run: 4, fin: 1'b0, sw: 1'b1, stray: 1'b0, cpc: 32'h0000_047C, csp: 32'h0000_7FF0,
                   exp_sw: 1'b1, exp_pc: 32'h0000_047C, exp_sp: 32'h0000_7FF0};
        tbl[2] = '{tid: 6'd63, pixel: 32'hFFFF_FFFF, pc: 32'h8000_0000, sp: 32'h0000_0010,
                   origin: 128'd0, dir: 128'd1,
                   run: 0, fin: 1'b1, sw: 1'b1, stray: 1'b0, cpc: 32'h0000_0111, csp: 32'h0000_0222,
                   exp_sw: 1'b0, exp_pc: 32'd0, exp_sp: 32'd0};
        tbl[3] = '{tid: 6'd0, pixel: 32'h0000_0007, pc: 32'h0000_2000, sp: 32'h0000_3000,
                   origin: 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001, dir: 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A,
                   run: 1, fin: 1'b0, sw: 1'b1, stray: 1'b1, cpc: 32'hFFFF_FFFC, csp: 32'h0000_0010,
                   exp_sw: 1'b1, exp_pc: 32'hFFFF_FFFC, exp_sp: 32'h0000_0010};
        wd_v = tbl[1];
        wd_v.tid = 6'd9; wd_v.cpc = 32'h0000_0500; wd_v.csp = 32'h0000_6FF0;
        wd_v.exp_pc = 32'h0000_0500; wd_v.exp_sp = 32'h0000_6FF0;
        bp_v = tbl[2];
        bp_v.tid = 6'd17;
        rs_v = tbl[0];
        rs_v.tid = 6'd33;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_task_ready", bus.task_ready, 1'b1);
        check("rst_kernel_mode", bus.kernel_mode, 1'b1);
        check("rst_rpt_valid", bus.rpt_valid, 1'b0);
        check("rst_s_wen", bus.s_wen, 1'b0);
        check("rst_v_wen", bus.v_wen, 1'b0);
        check("rst_core_start", bus.core_start, 1'b0);
        check("rst_preempt", bus.preempt, 1'b0);
        check("rst_rpt_tid", bus.rpt_tid, 6'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            launch(tbl[i]);
            for (int k = 0; k < tbl[i].run; k++) begin
                check("run_preempt", bus.preempt, 1'b0);
                check("run_no_report", bus.rpt_valid, 1'b0);
                @(negedge clk);
            end
            report(tbl[i]);
        end

        // Watchdog: preempt rises on RUN cycle 10, context switch on cycle 13
        launch(wd_v);
        for (int k = 0; k < 10; k++) begin
            check("wd_preempt_low", bus.preempt, 1'b0);
            @(negedge clk);
        end
        for (int k = 10; k < 14; k++) begin
            check("wd_preempt_high", bus.preempt, 1'b1);
            if (k < 13) @(negedge clk);
        end
        report(wd_v);

        // Report backpressure with a pending new descriptor
        launch(bp_v);
        bus.task_finish_in = 1'b1; bus.context_switch_in = 1'b1;
        bus.core_pc_in = 32'h0000_0111; bus.core_sp_in = 32'h0000_0222;
        @(negedge clk);
        bus.task_finish_in = 1'b0; bus.context_switch_in = 1'b0;
        bus.task_valid = 1'b1; bus.task_tid = 6'd1; bus.task_pixel = 32'h0000_0099;
        for (int k = 0; k < 5; k++) begin
            check("bp_rpt_valid", bus.rpt_valid, 1'b1);
            check("bp_rpt_tid", bus.rpt_tid, 6'd17);
            check("bp_rpt_switched", bus.rpt_switched, 1'b0);
            check("bp_rpt_pc", bus.rpt_pc, 32'd0);
            check("bp_task_ready", bus.task_ready, 1'b0);
            check("bp_s_wen", bus.s_wen, 1'b0);
            @(negedge clk);
        end
        bus.rpt_ready = 1'b1;
        @(negedge clk);
        bus.rpt_ready = 1'b0;
        bus.task_valid = 1'b0;
        check("bp_release_rpt_valid", bus.rpt_valid, 1'b0);
        check("bp_release_task_ready", bus.task_ready, 1'b1);
        @(negedge clk);
        check("bp_not_accepted_s_wen", bus.s_wen, 1'b0);
        check("bp_not_accepted_ready", bus.task_ready, 1'b1);

        // Reset in the middle of RUN while preempt is asserted
        launch(rs_v);
        for (int k = 0; k < 11; k++) @(negedge clk);
        check("rs_preempt_before", bus.preempt, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rs_async_kernel_mode", bus.kernel_mode, 1'b1);
        check("rs_async_preempt", bus.preempt, 1'b0);
        @(negedge clk);
        check("rs_kernel_mode", bus.kernel_mode, 1'b1);
        check("rs_task_ready", bus.task_ready, 1'b1);
        check("rs_rpt_valid", bus.rpt_valid, 1'b0);
        check("rs_preempt", bus.preempt, 1'b0);
        rst_n = 1'b1;
        bus.task_finish_in = 1'b1;
        @(negedge clk);
        bus.task_finish_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rs_no_report", bus.rpt_valid, 1'b0);
            check("rs_idle_ready", bus.task_ready, 1'b1);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
